// File: rtl/efpga_cpu_io_ctrl_if.sv
// CPU operand/result handshake and the OPA/OPB/RES fabric lanes of the east-edge CPU I/O tile.
// The slave modport is the controller's view; the master modport is the CPU/fabric side.
interface efpga_cpu_io_ctrl_if;
   logic        cpu_valid;
   logic        cpu_ready;
   logic [31:0] cpu_opa;
   logic [31:0] cpu_opb;
   logic        cpu_res_valid;
   logic        cpu_res_ready;
   logic [31:0] cpu_res;
   logic        cpu_err;
   logic [3:0]  opa_o;
   logic [3:0]  opb_o;
   logic        op_strobe;
   logic        op_first;
   logic [3:0]  res0_i;
   logic [3:0]  res1_i;
   logic [3:0]  res2_i;

   modport slave (
      input  cpu_valid, cpu_opa, cpu_opb, cpu_res_ready, res0_i, res1_i, res2_i,
      output cpu_ready, cpu_res_valid, cpu_res, cpu_err, opa_o, opb_o, op_strobe, op_first
   );

   modport master (
      output cpu_valid, cpu_opa, cpu_opb, cpu_res_ready, res0_i, res1_i, res2_i,
      input  cpu_ready, cpu_res_valid, cpu_res, cpu_err, opa_o, opb_o, op_strobe, op_first
   );
endinterface

// File: rtl/efpga_cpu_io_ctrl.sv
// CPU custom-instruction sequencer: streams operand nibbles to the fabric, gathers four result beats.
// Optional result-beat timeout abort is built when EFPGA_IO_CTRL_TIMEOUT_EN is defined.
module efpga_cpu_io_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                UserCLK,
   input  logic                reset,
   efpga_cpu_io_ctrl_if.slave  io
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      COLLECT = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  nib_q, nib_d;
   logic [1:0]  beat_q, beat_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] res_q, res_d;
   logic [3:0]  opa_o_q, opa_o_d;
   logic [3:0]  opb_o_q, opb_o_d;
   logic        op_strobe_q, op_strobe_d;
   logic        op_first_q, op_first_d;
   logic        res_valid_q, res_valid_d;
   logic        beat_vld;
   logic        unused_res2;

`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
   localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] idle_q, idle_d;
   logic        err_q, err_d;
`else
   localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

   assign beat_vld    = io.res2_i[0];
   assign unused_res2 = ^io.res2_i[3:1];

   always_comb begin
      state_d     = state_q;
      nib_d       = nib_q;
      beat_d      = beat_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      res_d       = res_q;
      opa_o_d     = '0;
      opb_o_d     = '0;
      op_strobe_d = 1'b0;
      op_first_d  = 1'b0;
      res_valid_d = 1'b0;
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
      idle_d      = idle_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (io.cpu_valid) begin
               // Nibble 0 goes straight to the lanes; the shift registers keep the rest.
               opa_o_d     = io.cpu_opa[3:0];
               opb_o_d     = io.cpu_opb[3:0];
               opa_d       = io.cpu_opa >> 4;
               opb_d       = io.cpu_opb >> 4;
               op_strobe_d = 1'b1;
               op_first_d  = 1'b1;
               nib_d       = '0;
               beat_d      = '0;
               res_d       = '0;
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
               idle_d      = '0;
               err_d       = 1'b0;
`endif
               state_d     = SEND;
            end
         end
         SEND: begin
            if (nib_q == 3'd7) begin
               state_d = COLLECT;
            end else begin
               opa_o_d     = opa_q[3:0];
               opb_o_d     = opb_q[3:0];
               op_strobe_d = 1'b1;
               opa_d       = opa_q >> 4;
               opb_d       = opb_q >> 4;
               nib_d       = nib_q + 3'd1;
            end
         end
         COLLECT: begin
            // A beat always wins over the idle limit reached in the same cycle.
            if (beat_vld) begin
               res_d[{beat_q, 3'b000} +: 8] = {io.res1_i, io.res0_i};
               beat_d = beat_q + 2'd1;
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
               idle_d = '0;
`endif
               if (beat_q == 2'd3) begin
                  state_d     = DONE;
                  res_valid_d = 1'b1;
               end
            end
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
            else if (idle_q == IDLE_LAST) begin
               state_d     = DONE;
               res_valid_d = 1'b1;
               err_d       = 1'b1;
            end else begin
               idle_d = idle_q + 16'd1;
            end
`endif
         end
         DONE: begin
            if (io.cpu_res_ready) begin
               state_d = IDLE;
            end else begin
               res_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         state_q     <= IDLE;
         nib_q       <= '0;
         beat_q      <= '0;
         res_q       <= '0;
         opa_o_q     <= '0;
         opb_o_q     <= '0;
         op_strobe_q <= 1'b0;
         op_first_q  <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
         idle_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         nib_q       <= nib_d;
         beat_q      <= beat_d;
         res_q       <= res_d;
         opa_o_q     <= opa_o_d;
         opb_o_q     <= opb_o_d;
         op_strobe_q <= op_strobe_d;
         op_first_q  <= op_first_d;
         res_valid_q <= res_valid_d;
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
         idle_q      <= idle_d;
         err_q       <= err_d;
`endif
      end
   end

   // Operand shift registers are pure data and are always reloaded on accept.
   always_ff @(posedge UserCLK) begin
      opa_q <= opa_d;
      opb_q <= opb_d;
   end

   // Held low during reset so the CPU cannot hand over operands that would be lost.
   assign io.cpu_ready     = (state_q == IDLE) && !reset;
   assign io.cpu_res_valid = res_valid_q;
   assign io.cpu_res       = res_q;
   assign io.opa_o         = opa_o_q;
   assign io.opb_o         = opb_o_q;
   assign io.op_strobe     = op_strobe_q;
   assign io.op_first      = op_first_q;
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
   assign io.cpu_err       = err_q;
`else
   assign io.cpu_err       = 1'b0;
`endif

endmodule

// File: tb/tb_efpga_cpu_io_ctrl.sv
// Bench for efpga_cpu_io_ctrl: randomized transfers, scoreboard queues, decoupled monitors.
// Timeout scenarios are exercised when EFPGA_IO_CTRL_TIMEOUT_EN is defined.
module tb_efpga_cpu_io_ctrl;
   localparam int TO = 4;

   typedef struct {
      logic       first;
      logic [3:0] a;
      logic [3:0] b;
      int         due;
   } nib_t;

   typedef struct {
      logic [31:0] res;
      logic        err;
      int          due;
   } res_t;

   logic UserCLK = 1'b0;
   logic reset   = 1'b1;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   int   last_consume = -10;
   nib_t nib_sb[$];
   res_t res_sb[$];

   efpga_cpu_io_ctrl_if bus ();

   efpga_cpu_io_ctrl #(.TIMEOUT_CYC(TO)) u_dut (
      .UserCLK (UserCLK),
      .reset   (reset),
      .io      (bus)
   );

   always #5 UserCLK = ~UserCLK;
   always @(posedge UserCLK) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   task automatic step();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic drive_noise(input bit allow_vld);
      bus.res0_i        = 4'($urandom);
      bus.res1_i        = 4'($urandom);
      bus.res2_i        = {3'($urandom), allow_vld ? 1'($urandom) : 1'b0};
      bus.cpu_res_ready = 1'($urandom);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_opa_o"}, bus.opa_o, 0);
      chk({tag, "_opb_o"}, bus.opb_o, 0);
      chk({tag, "_op_strobe"}, bus.op_strobe, 0);
      chk({tag, "_op_first"}, bus.op_first, 0);
      chk({tag, "_res_valid"}, bus.cpu_res_valid, 0);
      chk({tag, "_cpu_res"}, bus.cpu_res, 0);
      chk({tag, "_cpu_err"}, bus.cpu_err, 0);
   endtask

   // Presents an operand pair and waits for the accepting cycle; queues the expected nibble stream.
   task automatic wait_accept(input logic [31:0] a, input logic [31:0] b, input int exp_cyc,
                              output int acc);
      bit ok;
      ok  = 1'b0;
      acc = -1;
      bus.cpu_valid = 1'b1;
      bus.cpu_opa   = a;
      bus.cpu_opb   = b;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge UserCLK);
         if (bus.cpu_ready) begin
            ok  = 1'b1;
            acc = cyc;
            for (int k = 0; k < 8; k++)
               nib_sb.push_back('{first: (k == 0), a: a[4*k +: 4], b: b[4*k +: 4], due: acc + 1 + k});
         end
         step();
      end
      if (!ok) fail_bound("accept_wait");
      else if (exp_cyc >= 0) chk("b2b_accept_cycle", acc, exp_cyc);
   endtask

   task automatic run_xfer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] beats,
                           input int nbeats, input int gap, input int rdy_dly, input bit keep,
                           input logic [31:0] na, input logic [31:0] nbv, input int exp_acc);
      int          acc, g, done_cyc;
      bit          got;
      logic [31:0] exp_res;
      exp_res = '0;
      wait_accept(a, b, exp_acc, acc);
      if (keep) begin
         bus.cpu_opa = na;
         bus.cpu_opb = nbv;
      end else begin
         bus.cpu_valid = 1'b0;
      end
      repeat (8) begin
         drive_noise(1'b1);
         step();
      end
      for (int i = 0; i < nbeats; i++) begin
         g = (gap < 0) ? int'($urandom_range(0, TO - 1)) : gap;
         repeat (g) begin
            drive_noise(1'b0);
            step();
         end
         bus.res0_i        = beats[8*i +: 4];
         bus.res1_i        = beats[8*i+4 +: 4];
         bus.res2_i        = {3'($urandom), 1'b1};
         bus.cpu_res_ready = 1'($urandom);
         exp_res[8*i +: 8] = beats[8*i +: 8];
         step();
      end
      done_cyc = cyc + ((nbeats < 4) ? TO : 0);
      res_sb.push_back('{res: exp_res, err: (nbeats < 4), due: done_cyc});
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         bus.cpu_res_ready = (cyc >= done_cyc + rdy_dly);
         bus.res0_i        = 4'($urandom);
         bus.res1_i        = 4'($urandom);
         bus.res2_i        = {3'($urandom), (cyc >= done_cyc) ? 1'($urandom) : 1'b0};
         @(negedge UserCLK);
         if (bus.cpu_res_valid && bus.cpu_res_ready) begin
            got          = 1'b1;
            last_consume = cyc;
         end
         step();
      end
      bus.cpu_res_ready = 1'b0;
      bus.res2_i        = '0;
      if (!got) fail_bound("result_wait");
   endtask

   // Starts a transfer, feeds nb_before beats, then pulses reset rst_off cycles after the accept edge.
   task automatic xfer_reset(input logic [31:0] a, input logic [31:0] b, input int rst_off,
                             input int nb_before);
      int acc;
      wait_accept(a, b, -1, acc);
      bus.cpu_valid = 1'b0;
      for (int c = 1; c < rst_off; c++) begin
         if (c <= 8) drive_noise(1'b1);
         else if (c - 9 < nb_before) begin
            drive_noise(1'b0);
            bus.res2_i[0] = 1'b1;
         end else drive_noise(1'b0);
         step();
      end
      reset = 1'b1;
      drive_noise(1'b1);
      @(negedge UserCLK);
      chk("ready_low_in_reset", bus.cpu_ready, 0);
      step();
      reset = 1'b0;
      nib_sb.delete();
      bus.res2_i        = '0;
      bus.cpu_res_ready = 1'b0;
      @(negedge UserCLK);
      chk_outputs_zero("after_reset");
      chk("after_reset_ready", bus.cpu_ready, 1);
      step();
   endtask

   initial begin : nib_mon
      nib_t e;
      forever begin
         @(negedge UserCLK);
         if (mon_en && !reset) begin
            if (bus.op_strobe) begin
               if (nib_sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL nib_extra: strobe with opa_o=%0h opb_o=%0h, required none (cycle %0d)",
                           bus.opa_o, bus.opb_o, cyc);
               end else begin
                  e = nib_sb.pop_front();
                  chk("nib_opa", bus.opa_o, e.a);
                  chk("nib_opb", bus.opb_o, e.b);
                  chk("nib_first", bus.op_first, e.first);
                  chk("nib_cycle", cyc, e.due);
               end
            end else begin
               chk("idle_lanes", {bus.opa_o, bus.opb_o, bus.op_first}, 0);
            end
         end
      end
   end

   initial begin : res_mon
      bit          prev_v, hs_prev;
      logic [32:0] prev;
      logic [31:0] last_res;
      res_t        e;
      prev_v   = 1'b0;
      hs_prev  = 1'b0;
      prev     = '0;
      last_res = '0;
      forever begin
         @(negedge UserCLK);
         if (!mon_en || reset) begin
            prev_v  = 1'b0;
            hs_prev = 1'b0;
         end else begin
            if (hs_prev) begin
               chk("post_consume_ready", bus.cpu_ready, 1);
               chk("post_consume_valid", bus.cpu_res_valid, 0);
               chk("post_consume_res_kept", bus.cpu_res, last_res);
            end
            if (bus.cpu_res_valid) begin
               chk("ready_low_in_done", bus.cpu_ready, 0);
               if (prev_v) chk("done_stable", {bus.cpu_err, bus.cpu_res}, prev);
               else if (res_sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL res_extra: cpu_res_valid with res=%0h, required no result (cycle %0d)",
                           bus.cpu_res, cyc);
               end else chk("res_latency", cyc, res_sb[0].due);
               if (bus.cpu_res_ready && res_sb.size() != 0) begin
                  e = res_sb.pop_front();
                  chk("res_value", bus.cpu_res, e.res);
                  chk("res_err", bus.cpu_err, e.err);
                  last_res = e.res;
               end
            end
            prev_v  = bus.cpu_res_valid;
            prev    = {bus.cpu_err, bus.cpu_res};
            hs_prev = bus.cpu_res_valid && bus.cpu_res_ready;
         end
      end
   end

   initial begin : stim
      logic [31:0] p[3][2];
      bus.cpu_valid     = 1'b0;
      bus.cpu_opa       = '0;
      bus.cpu_opb       = '0;
      bus.cpu_res_ready = 1'b0;
      bus.res0_i        = '0;
      bus.res1_i        = '0;
      bus.res2_i        = '0;
      reset             = 1'b1;
      repeat (3) @(posedge UserCLK);
      @(negedge UserCLK);
      chk_outputs_zero("reset");
      chk("reset_ready", bus.cpu_ready, 0);
      step();
      reset = 1'b0;
      @(negedge UserCLK);
      chk("ready_after_reset", bus.cpu_ready, 1);
      mon_en = 1'b1;
      step();

      run_xfer(32'h8765_4321, 32'hFEDC_BA98, 32'h4433_2211, 4, 0, 0, 1'b0, '0, '0, -1);
      run_xfer($urandom, $urandom, $urandom, 4, 3, 5, 1'b0, '0, '0, -1);
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
      run_xfer($urandom, $urandom, 32'h0000_BBAA, 2, 0, 1, 1'b0, '0, '0, -1);
      run_xfer($urandom, $urandom, 32'hC3C2_C1C0, 4, TO - 1, 0, 1'b0, '0, '0, -1);
      run_xfer($urandom, $urandom, 32'h0, 0, 0, 2, 1'b0, '0, '0, -1);
`endif
      xfer_reset($urandom, $urandom, 5, 0);
      run_xfer($urandom, $urandom, $urandom, 4, -1, 1, 1'b0, '0, '0, -1);
      xfer_reset($urandom, $urandom, 11, 2);
`ifdef EFPGA_IO_CTRL_TIMEOUT_EN
      run_xfer($urandom, $urandom, 32'h0000_005A, 1, 1, 0, 1'b0, '0, '0, -1);
`else
      run_xfer($urandom, $urandom, $urandom, 4, 0, 0, 1'b0, '0, '0, -1);
`endif

      for (int i = 0; i < 3; i++) begin
         p[i][0] = $urandom;
         p[i][1] = $urandom;
      end
      run_xfer(p[0][0], p[0][1], $urandom, 4, -1, 0, 1'b1, p[1][0], p[1][1], -1);
      run_xfer(p[1][0], p[1][1], $urandom, 4, -1, 2, 1'b1, p[2][0], p[2][1], last_consume + 1);
      run_xfer(p[2][0], p[2][1], $urandom, 4, -1, 0, 1'b0, '0, '0, last_consume + 1);

      for (int i = 0; i < 20; i++)
         run_xfer($urandom, $urandom, $urandom, 4, -1, int'($urandom_range(0, 3)), 1'b0, '0, '0, -1);

      repeat (5) step();
      chk("nib_queue_drained", nib_sb.size(), 0);
      chk("res_queue_drained", res_sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/efpga_cpu_io_ctrl.md
# efpga_cpu_io_ctrl

Sequences CPU custom-instruction transfers through the east-edge CPU I/O tile of the eFPGA. The block accepts 32-bit operand pairs from the CPU and streams them as 4-bit nibbles onto the OPA/OPB fabric lanes. It then collects a 32-bit result from the RES0/RES1 lanes, qualified by strobes on RES2, and returns it to the CPU with a ready/valid handshake. The timeout is optional.

## Interface
Parameters:
- TIMEOUT_CYC, 255: maximum number of idle cycles between result beats before the transfer is aborted. Range 1..65535.

Ports:
- UserCLK  in  1  fabric user clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  CPU presents operands.
- cpu_ready  out  1  block accepts operands. High only in IDLE.
- cpu_opa  in  32  operand A.
- cpu_opb  in  32  operand B.
- cpu_res_valid  out  1  result available.
- cpu_res_ready  in  1  CPU consumes the result.
- cpu_res  out  32  result word.
- cpu_err  out  1  transfer aborted by timeout. Valid with cpu_res_valid.
- opa_o  out  4  operand A nibble to the fabric (OPA_O lane).
- opb_o  out  4  operand B nibble to the fabric (OPB_O lane).
- op_strobe  out  1  nibble on opa_o/opb_o is valid.
- op_first  out  1  marks nibble 0 of a frame.
- res0_i  in  4  result beat, low nibble.
- res1_i  in  4  result beat, high nibble.
- res2_i  in  4  fabric control lane: [0] beat valid, [3:1] reserved and ignored.

## Operation
- Reset values: every output is 0, state is IDLE, counters are 0. cpu_ready is 0 while reset is high and 1 from the first cycle after reset.
- IDLE:
  - cpu_ready=1.
  - When cpu_valid && cpu_ready, latch cpu_opa/cpu_opb, clear the result register and cpu_err, and go to SEND.
- SEND: 8 cycles, nibble index k = 0..7, least-significant nibble first.
  - opa_o = opa[4k+3:4k], opb_o = opb[4k+3:4k].
  - op_strobe=1. op_first=1 only when k=0.
  - After k=7, go to COLLECT.
  - res2_i is ignored during SEND.
- COLLECT: beat counter b = 0..3.
  - Each cycle with res2_i[0]=1 writes {res1_i,res0_i} into res[8b+7:8b], increments b and clears the idle counter.
  - Each cycle with res2_i[0]=0 increments the idle counter.
  - After beat 3, go to DONE.
- DONE:
  - cpu_res_valid=1; cpu_res and cpu_err are held stable.
  - On cpu_res_ready, go to IDLE.
  - cpu_res_valid=0 after that edge; cpu_res keeps its last value.
- Timeout (macro enabled only): when the idle counter reaches TIMEOUT_CYC in COLLECT, go to DONE with cpu_err=1. cpu_res holds the beats received so far; bytes not received read 0.
- Outputs in every state other than SEND: opa_o=0, opb_o=0, op_strobe=0, op_first=0.
- A reset asserted in any state wins over everything else:
  - return to IDLE;
  - discard the partial result;
  - drop cpu_res_valid on the next edge.
- Only one transfer is in flight at a time; no new operands are accepted until the result has been consumed.

## Timing
- All outputs except cpu_ready are registered. cpu_ready is decoded from the state register.
- The accept edge is T. Nibble k is driven in cycle T+1+k; op_first is high in T+1.
- COLLECT starts at T+9, the earliest cycle in which a beat is sampled.
- With 4 back-to-back beats at T+9..T+12, cpu_res_valid=1 at T+13. Minimum accept-to-result latency is 13 cycles.
- A beat sampled in the same cycle the idle counter would reach TIMEOUT_CYC is accepted, and the timeout does not fire.
- If cpu_res_ready is high in the first DONE cycle, DONE lasts exactly 1 cycle. The earliest next accept is 2 cycles after DONE is entered.
- cpu_valid held high across DONE is not accepted until the IDLE cycle.

## Configuration
- EFPGA_IO_CTRL_TIMEOUT_EN:
  - Defined: the idle counter (16 bits) and the timeout abort are implemented.
  - Undefined: COLLECT waits indefinitely for 4 beats, cpu_err is tied to 0, and no timeout logic is synthesized.

## Test plan
- Basic transfer: opa=0x8765_4321, opb=0xFEDC_BA98, fabric returns beats 0x11,0x22,0x33,0x44 at T+9..T+12 -> opa_o sequence 1,2,3,4,5,6,7,8; opb_o 8,9,A,B,C,D,E,F; op_first only at T+1; cpu_res=0x4433_2211 with cpu_res_valid at T+13; cpu_err=0.
- Gapped beats: 3 idle cycles between each beat, cpu_res_ready held low for 5 cycles -> result correct; cpu_res and cpu_res_valid stable throughout DONE; cpu_ready=0 until the cycle after the consuming edge.
- Timeout (macro on, TIMEOUT_CYC=4): 2 beats 0xAA,0xBB, then silence -> DONE 4 idle cycles after the last beat; cpu_err=1; cpu_res=0x0000_BBAA.
- Boundary: with TIMEOUT_CYC=4, a beat arrives on the 4th idle cycle -> beat accepted, no timeout.
- Reset mid-transfer: assert reset at T+5 (SEND) and again during COLLECT -> next cycle every output is 0 and the state is IDLE; a following transfer completes correctly with no stale bytes.
- Back-to-back: cpu_valid held high with 3 operand pairs -> each pair accepted only in IDLE; results returned in order; no extra accepts during SEND, COLLECT or DONE.
